// File: rtl/oled_pkg.sv
// Shared constants for the SSD1309 SPI sink: geometry defaults, addressing modes,
// opcodes and the argument-count table for commands whose arguments are consumed silently.
package oled_pkg;

    localparam int unsigned COLS_DEFAULT  = 128;
    localparam int unsigned PAGES_DEFAULT = 8;

    localparam logic [1:0] ADDR_HORZ = 2'b00;
    localparam logic [1:0] ADDR_VERT = 2'b01;
    localparam logic [1:0] ADDR_PAGE = 2'b10;

    localparam logic [7:0] OP_SET_MODE   = 8'h20;
    localparam logic [7:0] OP_SET_COL    = 8'h21;
    localparam logic [7:0] OP_SET_PAGE   = 8'h22;
    localparam logic [7:0] OP_PAGE_START = 8'hB0;

    typedef enum logic [2:0] {
        StIdle,
        StArgMode,
        StArgCol0,
        StArgCol1,
        StArgPg0,
        StArgPg1,
        StSkip
    } cmd_state_e;

    function automatic logic [2:0] arg_count(input logic [7:0] b);
        logic [2:0] n;
        case (b)
            8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'hFD: n = 3'd1;
            8'hA3:                                                  n = 3'd2;
            8'h26, 8'h27, 8'h29, 8'h2A:                             n = 3'd6;
            default:                                                n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Pin synchronizers, SCLK rising-edge detect and the 8-bit MSB-first deserializer.
// Emits one byte_valid pulse per completed byte together with the DC level of its 8th bit.
module spi_byte_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_pin,
    input  logic       sdin_pin,
    input  logic       dc_pin,
    input  logic       cs_pin,
    input  logic       res_pin,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       is_data,
    output logic       res_clear
);

    // Bit order in the synchronizer vectors: {res, cs, dc, sdin, sclk}
    logic [4:0] sync1_q, sync2_q;
    logic       sclk_d_q, cs_d_q;
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;

    logic sclk_rise, cs_active;

    assign sclk_rise = sync2_q[0] & ~sclk_d_q;
    // Still active in the first cycle CS reads high so a byte finishing on that edge completes.
    assign cs_active = ~sync2_q[3] | ~cs_d_q;
    assign res_clear = ~sync2_q[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 5'b11000;
            sync2_q    <= 5'b11000;
            sclk_d_q   <= 1'b0;
            cs_d_q     <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            is_data    <= 1'b0;
        end else begin
            sync1_q    <= {res_pin, cs_pin, dc_pin, sdin_pin, sclk_pin};
            sync2_q    <= sync1_q;
            sclk_d_q   <= sync2_q[0];
            cs_d_q     <= sync2_q[3];
            byte_valid <= 1'b0;
            if (res_clear) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
            end else if (sclk_rise && cs_active) begin
                shift_q   <= {shift_q[5:0], sync2_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= {shift_q, sync2_q[1]};
                    is_data    <= sync2_q[2];
                end
            end else if (sync2_q[3]) begin
                bit_cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/ssd1309_spi_sink.sv
// SSD1309 4-wire SPI receive mirror: decodes the command stream, tracks addressing state
// and emits one framebuffer write per GDDRAM data byte.
module ssd1309_spi_sink
    import oled_pkg::*;
#(
    parameter int unsigned COLS  = COLS_DEFAULT,
    parameter int unsigned PAGES = PAGES_DEFAULT,
    localparam int unsigned CW   = $clog2(COLS),
    localparam int unsigned PW   = $clog2(PAGES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk_pin,
    input  logic          sdin_pin,
    input  logic          dc_pin,
    input  logic          cs_pin,
    input  logic          res_pin,
    output logic          px_we,
    output logic [CW-1:0] px_col,
    output logic [PW-1:0] px_page,
    output logic [7:0]    px_data,
    output logic          cmd_valid,
    output logic [7:0]    cmd_byte,
    output logic [1:0]    addr_mode,
    output logic          proto_err
);

    logic       byte_valid, is_data, res_clear;
    logic [7:0] rx_byte;

    spi_byte_rx u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk_pin   (sclk_pin),
        .sdin_pin   (sdin_pin),
        .dc_pin     (dc_pin),
        .cs_pin     (cs_pin),
        .res_pin    (res_pin),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .is_data    (is_data),
        .res_clear  (res_clear)
    );

    cmd_state_e    state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [1:0]    mode_d;
    logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic          px_we_d, cmd_valid_d, proto_err_d;
    logic [CW-1:0] px_col_d;
    logic [PW-1:0] px_page_d;
    logic [7:0]    px_data_d, cmd_byte_d;
    logic [CW-1:0] col_inc;
    logic [PW-1:0] page_inc;

    assign col_inc  = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
    assign page_inc = (page_q == PW'(PAGES - 1)) ? '0 : page_q + PW'(1);

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        mode_d       = addr_mode;
        col_d        = col_q;
        page_d       = page_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        px_we_d      = 1'b0;
        cmd_valid_d  = 1'b0;
        proto_err_d  = 1'b0;
        px_col_d     = px_col;
        px_page_d    = px_page;
        px_data_d    = px_data;
        cmd_byte_d   = cmd_byte;

        if (byte_valid && is_data) begin
            px_we_d   = 1'b1;
            px_col_d  = col_q;
            px_page_d = page_q;
            px_data_d = rx_byte;
            if (state_q != StIdle) begin
                state_d     = StIdle;
                proto_err_d = 1'b1;
            end
            case (addr_mode)
                ADDR_HORZ: begin
                    if (col_q == col_end_q) begin
                        col_d  = col_start_q;
                        page_d = (page_q == page_end_q) ? page_start_q : page_inc;
                    end else begin
                        col_d = col_inc;
                    end
                end
                ADDR_VERT: begin
                    if (page_q == page_end_q) begin
                        page_d = page_start_q;
                        col_d  = (col_q == col_end_q) ? col_start_q : col_inc;
                    end else begin
                        page_d = page_inc;
                    end
                end
                default: col_d = col_inc;
            endcase
        end else if (byte_valid) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = rx_byte;
            case (state_q)
                StIdle: begin
                    if (rx_byte == OP_SET_MODE) begin
                        state_d = StArgMode;
                    end else if (rx_byte == OP_SET_COL) begin
                        state_d = StArgCol0;
                    end else if (rx_byte == OP_SET_PAGE) begin
                        state_d = StArgPg0;
                    end else if (arg_count(rx_byte) != 3'd0) begin
                        state_d = StSkip;
                        skip_d  = arg_count(rx_byte);
                    end else if (rx_byte[7:4] == 4'h0) begin
                        col_d[3:0] = rx_byte[3:0];
                    end else if (rx_byte[7:3] == 5'b00010) begin
                        col_d[CW-1:4] = rx_byte[CW-5:0];
                    end else if (rx_byte[7:3] == OP_PAGE_START[7:3]) begin
                        page_d = rx_byte[PW-1:0];
                    end
                end
                StArgMode: begin
                    state_d = StIdle;
                    if (rx_byte[1:0] == 2'b11) proto_err_d = 1'b1;
                    else                       mode_d      = rx_byte[1:0];
                end
                StArgCol0: begin
                    state_d     = StArgCol1;
                    col_start_d = rx_byte[CW-1:0];
                    col_d       = rx_byte[CW-1:0];
                end
                StArgCol1: begin
                    state_d   = StIdle;
                    col_end_d = rx_byte[CW-1:0];
                end
                StArgPg0: begin
                    state_d      = StArgPg1;
                    page_start_d = rx_byte[PW-1:0];
                    page_d       = rx_byte[PW-1:0];
                end
                StArgPg1: begin
                    state_d    = StIdle;
                    page_end_d = rx_byte[PW-1:0];
                end
                StSkip: begin
                    if (skip_q == 3'd1) state_d = StIdle;
                    skip_d = skip_q - 3'd1;
                end
                default: state_d = StIdle;
            endcase
        end

        if (res_clear) begin
            state_d      = StIdle;
            skip_d       = '0;
            mode_d       = ADDR_PAGE;
            col_d        = '0;
            page_d       = '0;
            col_start_d  = '0;
            col_end_d    = CW'(COLS - 1);
            page_start_d = '0;
            page_end_d   = PW'(PAGES - 1);
            px_we_d      = 1'b0;
            cmd_valid_d  = 1'b0;
            proto_err_d  = 1'b0;
            px_col_d     = '0;
            px_page_d    = '0;
            px_data_d    = '0;
            cmd_byte_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            skip_q       <= '0;
            addr_mode    <= ADDR_PAGE;
            col_q        <= '0;
            page_q       <= '0;
            col_start_q  <= '0;
            col_end_q    <= CW'(COLS - 1);
            page_start_q <= '0;
            page_end_q   <= PW'(PAGES - 1);
            px_we        <= 1'b0;
            cmd_valid    <= 1'b0;
            proto_err    <= 1'b0;
            px_col       <= '0;
            px_page      <= '0;
            px_data      <= '0;
            cmd_byte     <= '0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            addr_mode    <= mode_d;
            col_q        <= col_d;
            page_q       <= page_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            px_we        <= px_we_d;
            cmd_valid    <= cmd_valid_d;
            proto_err    <= proto_err_d;
            px_col       <= px_col_d;
            px_page      <= px_page_d;
            px_data      <= px_data_d;
            cmd_byte     <= cmd_byte_d;
        end
    end

endmodule

// File: tb/tb_ssd1309_spi_sink.sv
// Bench for ssd1309_spi_sink: drives the SPI pins, predicts every strobe with a byte-level
// model of the command protocol and checks strobes from an independent monitor.
module tb_ssd1309_spi_sink;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk_pin = 1'b0, sdin_pin = 1'b0, dc_pin = 1'b0, cs_pin = 1'b1, res_pin = 1'b1;
    logic       px_we, cmd_valid, proto_err;
    logic [6:0] px_col;
    logic [2:0] px_page;
    logic [7:0] px_data, cmd_byte;
    logic [1:0] addr_mode;

    ssd1309_spi_sink dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk_pin  (sclk_pin),
        .sdin_pin  (sdin_pin),
        .dc_pin    (dc_pin),
        .cs_pin    (cs_pin),
        .res_pin   (res_pin),
        .px_we     (px_we),
        .px_col    (px_col),
        .px_page   (px_page),
        .px_data   (px_data),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .addr_mode (addr_mode),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit we;
        bit cv;
        bit err;
        int col;
        int page;
        int dat;
    } exp_t;

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference state: plain integers, pending opcode plus remaining argument count.
    int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_op, m_left, m_idx;

    function automatic void check(input string name, input bit ok, input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else    $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endfunction

    function automatic int ref_arg_count(input int b);
        if (b inside {8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'hFD}) return 1;
        if (b == 8'hA3) return 2;
        if (b inside {8'h26, 8'h27, 8'h29, 8'h2A}) return 6;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 2; m_col = 0; m_page = 0;
        m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
        m_op = 0; m_left = 0; m_idx = 0;
    endtask

    task automatic model_cmd(input int b);
        exp_t e;
        e.we = 0; e.cv = 1; e.err = 0; e.col = 0; e.page = 0; e.dat = b;
        if (m_left > 0) begin
            if (m_op == 32) begin
                if (b % 4 == 3) e.err = 1;
                else            m_mode = b % 4;
            end else if (m_op == 33) begin
                if (m_idx == 0) begin m_cs = b % 128; m_col = m_cs; end
                else            m_ce = b % 128;
            end else if (m_op == 34) begin
                if (m_idx == 0) begin m_ps = b % 8; m_page = m_ps; end
                else            m_pe = b % 8;
            end
            m_idx++;
            m_left--;
        end else begin
            m_op  = b;
            m_idx = 0;
            if (b == 32)                 m_left = 1;
            else if (b == 33 || b == 34) m_left = 2;
            else begin
                m_left = ref_arg_count(b);
                if (m_left == 0) begin
                    if (b < 16)                  m_col = (m_col / 16) * 16 + b;
                    else if (b < 24)             m_col = (b - 16) * 16 + m_col % 16;
                    else if (b >= 176 && b < 184) m_page = b - 176;
                end
            end
        end
        sbq.push_back(e);
    endtask

    task automatic model_data(input int b);
        exp_t e;
        e.we = 1; e.cv = 0; e.err = (m_left > 0); e.col = m_col; e.page = m_page; e.dat = b;
        m_left = 0;
        case (m_mode)
            0: if (m_col == m_ce) begin
                   m_col  = m_cs;
                   m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
               end else m_col = (m_col + 1) % 128;
            1: if (m_page == m_pe) begin
                   m_page = m_ps;
                   m_col  = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
               end else m_page = (m_page + 1) % 8;
            default: m_col = (m_col + 1) % 128;
        endcase
        sbq.push_back(e);
    endtask

    task automatic send_bits(input bit dc, input logic [7:0] b, input int n);
        cs_pin = 1'b0;
        dc_pin = dc;
        for (int i = 7; i > 7 - n; i--) begin
            sclk_pin = 1'b0;
            sdin_pin = b[i];
            repeat (4) @(negedge clk);
            sclk_pin = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_cmd(input int b);
        model_cmd(b);
        send_bits(1'b0, 8'(b), 8);
    endtask

    task automatic send_data(input int b);
        model_data(b);
        send_bits(1'b1, 8'(b), 8);
    endtask

    task automatic wait_drain();
        int budget = 200;
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain_pending_strobes", sbq.size() == 0, sbq.size(), 0);
        sbq.delete();
    endtask

    // Monitor: every strobe cycle must match the oldest predicted response.
    exp_t mon_e;
    bit   mon_ok;
    always @(negedge clk) begin
        if (rst_n && (px_we || cmd_valid || proto_err)) begin
            n_total++;
            if (sbq.size() == 0) begin
                $display("FAIL unexpected_strobe: we=%0b cv=%0b err=%0b col=%0d page=%0d data=%02h cmd=%02h, no strobe expected",
                         px_we, cmd_valid, proto_err, px_col, px_page, px_data, cmd_byte);
            end else begin
                mon_e  = sbq.pop_front();
                mon_ok = (px_we == mon_e.we) && (cmd_valid == mon_e.cv) && (proto_err == mon_e.err);
                if (mon_e.we) mon_ok = mon_ok && (px_col == 7'(mon_e.col)) &&
                                       (px_page == 3'(mon_e.page)) && (px_data == 8'(mon_e.dat));
                if (mon_e.cv) mon_ok = mon_ok && (cmd_byte == 8'(mon_e.dat));
                if (mon_ok) n_pass++;
                else $display("FAIL strobe: got we=%0b cv=%0b err=%0b col=%0d page=%0d data=%02h cmd=%02h, expected we=%0b cv=%0b err=%0b col=%0d page=%0d byte=%02h",
                              px_we, cmd_valid, proto_err, px_col, px_page, px_data, cmd_byte,
                              mon_e.we, mon_e.cv, mon_e.err, mon_e.col, mon_e.page, mon_e.dat);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int skip_ops[13] = '{8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'hFD,
                             8'hA3, 8'h26, 8'h27, 8'h29, 8'h2A};
        int op, n;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_px_we", px_we == 1'b0, px_we, 0);
        check("rst_cmd_valid", cmd_valid == 1'b0, cmd_valid, 0);
        check("rst_proto_err", proto_err == 1'b0, proto_err, 0);
        check("rst_addr_mode", addr_mode == 2'b10, addr_mode, 2);
        check("rst_px_col", px_col == 7'd0, px_col, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_data(8'hAA);
        send_data(8'h55);
        wait_drain();
        check("default_mode", addr_mode == 2'(m_mode), addr_mode, m_mode);

        send_cmd(8'h20); send_cmd(8'h00);
        send_cmd(8'h21); send_cmd(8'h7E); send_cmd(8'h7F);
        send_cmd(8'h22); send_cmd(8'h06); send_cmd(8'h07);
        for (int i = 0; i < 5; i++) send_data($urandom_range(0, 255));
        wait_drain();
        check("horz_mode", addr_mode == 2'(m_mode), addr_mode, m_mode);

        send_cmd(8'h20); send_cmd(8'h01);
        send_cmd(8'h21); send_cmd(8'h00); send_cmd(8'h7F);
        send_cmd(8'h22); send_cmd(8'h00); send_cmd(8'h07);
        for (int i = 0; i < 9; i++) send_data($urandom_range(0, 255));
        wait_drain();
        check("vert_mode", addr_mode == 2'(m_mode), addr_mode, m_mode);

        send_cmd(8'h20); send_cmd(8'h02);
        send_cmd(8'hB3); send_cmd(8'h0F); send_cmd(8'h17);
        send_data(8'h3C); send_data(8'hC3);
        wait_drain();

        send_cmd(8'h81);
        send_data(8'h12);
        wait_drain();

        // Partial byte abandoned by CS, then one complete byte.
        send_bits(1'b1, 8'hFF, 5);
        sclk_pin = 1'b0;
        repeat (4) @(negedge clk);
        cs_pin = 1'b1;
        repeat (10) @(negedge clk);
        send_data(8'hC3);
        wait_drain();

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0: begin send_cmd(8'h20); send_cmd($urandom_range(0, 3)); end
                1: begin send_cmd(8'h21); send_cmd($urandom_range(0, 255));
                         send_cmd($urandom_range(0, 255)); end
                2: begin send_cmd(8'h22); send_cmd($urandom_range(0, 255));
                         send_cmd($urandom_range(0, 255)); end
                3: send_cmd($urandom_range(0, 15));
                4: send_cmd($urandom_range(16, 23));
                5: send_cmd($urandom_range(176, 183));
                6: begin
                    op = skip_ops[$urandom_range(0, 12)];
                    send_cmd(op);
                    n = ref_arg_count(op);
                    for (int k = 0; k < n; k++) send_cmd($urandom_range(0, 255));
                end
                7: send_cmd($urandom_range(8'h40, 8'h7F));
                8: begin
                    op = $urandom_range(0, 2);
                    send_cmd(op == 0 ? 8'h20 : (op == 1 ? 8'h21 : 8'hA3));
                    send_data($urandom_range(0, 255));
                end
                default: begin
                    n = $urandom_range(1, 8);
                    for (int k = 0; k < n; k++) send_data($urandom_range(0, 255));
                end
            endcase
        end
        wait_drain();
        check("random_mode", addr_mode == 2'(m_mode), addr_mode, m_mode);

        // Display reset in the middle of a byte returns every pointer and mode to defaults.
        send_cmd(8'h20); send_cmd(8'h00);
        send_cmd(8'h21); send_cmd(8'h05); send_cmd(8'h09);
        send_cmd(8'hB4);
        send_data(8'h11); send_data(8'h22);
        wait_drain();
        check("pre_res_mode", addr_mode == 2'(m_mode), addr_mode, m_mode);
        send_bits(1'b1, 8'hF0, 3);
        res_pin = 1'b0;
        repeat (6) @(negedge clk);
        res_pin = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();
        check("res_addr_mode", addr_mode == 2'(m_mode), addr_mode, m_mode);
        send_data(8'h5A);
        send_data(8'hA5);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
